ripple_carry_adder: RTL and testbench
=====================================

Name: ripple_carry_adder

Overview:
- Parameterised WIDTH-bit unsigned/two's-complement adder built as an explicit chain of 1-bit full adders, carry rippling from bit 0 to bit WIDTH-1.
- Combinational sum/carry outputs for use inside datapaths.
- A registered copy of the result with status flags, for consumers that need a clocked boundary.
- Generic leaf arithmetic block in the combinational-circuit library.

Parameters:
- WIDTH, 4, operand/sum bit width; legal range 1..32.

Ports:
- i_Clk  input  1  clock; all registers update on the rising edge.
- i_Rst_n  input  1  synchronous active-low reset.
- i_A  input  WIDTH  operand A.
- i_B  input  WIDTH  operand B.
- i_Cin  input  1  carry into bit 0.
- i_En  input  1  capture enable for the registered stage.
- o_Sum  output  WIDTH  combinational sum bits.
- o_Cout  output  1  combinational carry out of bit WIDTH-1.
- o_Sum_q  output  WIDTH  registered sum.
- o_Cout_q  output  1  registered carry out.
- o_Ovf_q  output  1  registered signed overflow.
- o_Zero_q  output  1  registered flag: sum bits all zero.
- o_Valid_q  output  1  registered result is valid.

Behaviour:
- Structure: WIDTH full-adder instances, one per bit.
  - Bit k: s[k] = A[k]^B[k]^c[k]; c[k+1] = (A[k]&B[k]) | (c[k]&(A[k]^B[k])).
  - c[0] = i_Cin.
  - No carry-lookahead or behavioural "+" for the sum path.
- Combinational outputs:
  - {o_Cout, o_Sum} = i_A + i_B + i_Cin, exact (WIDTH+1)-bit result, no truncation.
  - Zero-latency; depend only on i_A, i_B, i_Cin.
  - Unaffected by i_Clk, i_Rst_n and i_En.
- Signed overflow (combinational, internal): ovf = c[WIDTH] ^ c[WIDTH-1].
  - Equivalently: A and B share a sign and the sum sign differs.
  - For WIDTH=1, ovf = c[1] ^ c[0].
- Registered stage, rising edge of i_Clk:
  - i_Rst_n=0: o_Sum_q=0, o_Cout_q=0, o_Ovf_q=0, o_Zero_q=0, o_Valid_q=0. Reset has priority over i_En.
  - Else if i_En=1: capture o_Sum, o_Cout, ovf, (o_Sum==0); o_Valid_q=1.
  - Else: all registered outputs hold, o_Valid_q included.
- Latency: 1 cycle from i_En sample to registered outputs.
- Back-to-back i_En captures a new result every cycle.
- Reset mid-operation clears the registered stage on that edge; combinational outputs keep tracking inputs.
- Wrap-around: all-ones + all-ones + 1 gives sum all-ones, carry 1.
  - o_Zero_q reflects the sum bits only, ignoring carry. 0xF+0x1 (WIDTH=4) gives o_Zero_q=1, o_Cout_q=1.
- No X propagation from the registered stage after reset.
- Inputs are assumed stable around the clock edge (single clock domain).

Test Plan:
- Exhaustive combinational sweep, WIDTH=4: walk {i_A,i_B,i_Cin} through all 512 values, one per 10 ns step. Every step {o_Cout,o_Sum} must equal A+B+Cin (e.g. A=1010, B=0111, Cin=1 -> Sum=0010, Cout=1).
- Carry ripple full length: A=1111, B=0000, Cin=1 -> Sum=0000, Cout=1. Then A=1111, B=1111, Cin=1 -> Sum=1111, Cout=1.
- Signed overflow: A=0111, B=0001, Cin=0, i_En=1, one clock -> o_Sum_q=1000, o_Ovf_q=1, o_Cout_q=0. Then A=1000, B=1000 -> o_Sum_q=0000, o_Cout_q=1, o_Ovf_q=1, o_Zero_q=1.
- Enable/hold: capture A=0011, B=0100 -> o_Sum_q=0111, o_Valid_q=1. Drop i_En and change inputs to A=0001, B=0001. Registered outputs must stay 0111 while o_Sum=0010 immediately.
- Synchronous reset: with o_Valid_q=1, assert i_Rst_n=0 with i_En=1 for one edge. All registered outputs must be 0, with no change before the edge. Combinational o_Sum must still follow the inputs.
- Parameter check, WIDTH=8: A=0xFF, B=0x01, Cin=0 -> o_Sum=0x00, o_Cout=1. After capture, o_Zero_q=1 and o_Ovf_q=0.

Source files
------------

// File: rtl/ripple_carry_adder.sv
// ripple_carry_adder: WIDTH-bit adder built from a chain of 1-bit full adders, with a registered result stage
// Ports:
//   i_Clk, i_Rst_n       clock and synchronous active-low reset
//   i_A, i_B, i_Cin      operands and carry into bit 0
//   i_En                 capture enable for the registered stage
//   o_Sum, o_Cout        combinational sum and carry out of bit WIDTH-1
//   o_Sum_q, o_Cout_q    registered sum and carry
//   o_Ovf_q, o_Zero_q    registered signed overflow and sum-bits-all-zero flags
//   o_Valid_q            registered result holds a captured value
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic [WIDTH-1:0] i_A,
    input  logic [WIDTH-1:0] i_B,
    input  logic             i_Cin,
    input  logic             i_En,
    output logic [WIDTH-1:0] o_Sum,
    output logic             o_Cout,
    output logic [WIDTH-1:0] o_Sum_q,
    output logic             o_Cout_q,
    output logic             o_Ovf_q,
    output logic             o_Zero_q,
    output logic             o_Valid_q
);
    logic [WIDTH:0] c;
    logic           ovf;
    assign c[0] = i_Cin;
    genvar k;
    generate
        for (k = 0; k < WIDTH; k++) begin : g_bit
            full_adder u_fa (
                .a (i_A[k]),
                .b (i_B[k]),
                .ci(c[k]),
                .s (o_Sum[k]),
                .co(c[k+1])
            );
        end
    endgenerate
    assign o_Cout = c[WIDTH];
    // Signed overflow: carry into the sign bit differs from carry out of it.
    assign ovf    = c[WIDTH] ^ c[WIDTH-1];
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            o_Sum_q   <= '0;
            o_Cout_q  <= 1'b0;
            o_Ovf_q   <= 1'b0;
            o_Zero_q  <= 1'b0;
            o_Valid_q <= 1'b0;
        end else if (i_En) begin
            o_Sum_q   <= o_Sum;
            o_Cout_q  <= o_Cout;
            o_Ovf_q   <= ovf;
            o_Zero_q  <= (o_Sum == '0);
            o_Valid_q <= 1'b1;
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// tb_ripple_carry_adder: checks 4-bit and 8-bit adders against an arithmetic reference model
module tb_ripple_carry_adder;
    logic       clk = 1'b0;
    logic       rst_n, cin, en;
    logic [3:0] a, b, sum4, sum_q4;
    logic [7:0] a8, b8, sum8, sum_q8;
    logic       cout4, cout_q4, ovf_q4, zero_q4, valid_q4;
    logic       cout8, cout_q8, ovf_q8, zero_q8, valid_q8;
    int         checks = 0;
    int         failures = 0;
    logic       chk_on = 1'b0;
    logic [35:0] m4, m8;
    logic [33:0] r4, r8;

    always #5 clk = ~clk;

    ripple_carry_adder #(.WIDTH(4)) dut4 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_A(a), .i_B(b), .i_Cin(cin), .i_En(en),
        .o_Sum(sum4), .o_Cout(cout4), .o_Sum_q(sum_q4), .o_Cout_q(cout_q4),
        .o_Ovf_q(ovf_q4), .o_Zero_q(zero_q4), .o_Valid_q(valid_q4)
    );
    ripple_carry_adder #(.WIDTH(8)) dut8 (
        .i_Clk(clk), .i_Rst_n(rst_n), .i_A(a8), .i_B(b8), .i_Cin(cin), .i_En(en),
        .o_Sum(sum8), .o_Cout(cout8), .o_Sum_q(sum_q8), .o_Cout_q(cout_q8),
        .o_Ovf_q(ovf_q8), .o_Zero_q(zero_q8), .o_Valid_q(valid_q8)
    );

    // Returns {signed_overflow, carry_out, sum[31:0]} from plain integer arithmetic.
    function automatic logic [33:0] ref_add(input int w, input logic [31:0] x, input logic [31:0] y, input logic ci);
        longint ux, uy, u, sx, sy, s, lim;
        logic   o, co;
        ux  = longint'(x);
        uy  = longint'(y);
        lim = longint'(1) << w;
        u   = ux + uy + longint'(ci);
        sx  = x[w-1] ? ux - lim : ux;
        sy  = y[w-1] ? uy - lim : uy;
        s   = sx + sy + longint'(ci);
        o   = (s >= lim / 2) || (s < -(lim / 2));
        co  = (u >= lim);
        return {o, co, 32'(u & (lim - 1))};
    endfunction

    assign r4 = ref_add(4, {28'b0, a}, {28'b0, b}, cin);
    assign r8 = ref_add(8, {24'b0, a8}, {24'b0, b8}, cin);

    // Registered-stage model: {valid, zero, ovf, cout, sum}.
    always @(posedge clk) begin
        if (!rst_n) begin
            m4 <= '0;
            m8 <= '0;
        end else if (en) begin
            m4 <= {1'b1, r4[31:0] == 32'd0, r4[33], r4[32], r4[31:0]};
            m8 <= {1'b1, r8[31:0] == 32'd0, r8[33], r8[32], r8[31:0]};
        end
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            check("sum4", {28'b0, sum4}, r4[31:0]);
            check("cout4", {31'b0, cout4}, {31'b0, r4[32]});
            check("sum8", {24'b0, sum8}, r8[31:0]);
            check("cout8", {31'b0, cout8}, {31'b0, r8[32]});
            check("sum_q4", {28'b0, sum_q4}, m4[31:0]);
            check("flags_q4", {28'b0, valid_q4, zero_q4, ovf_q4, cout_q4}, {28'b0, m4[35:32]});
            check("sum_q8", {24'b0, sum_q8}, m8[31:0]);
            check("flags_q8", {28'b0, valid_q8, zero_q8, ovf_q8, cout_q8}, {28'b0, m8[35:32]});
        end
    end

    task automatic step(input logic [3:0] ai, input logic [3:0] bi, input logic ci, input logic ei,
                        input logic ri, input logic [7:0] a8i, input logic [7:0] b8i);
        @(posedge clk);
        #1;
        a = ai; b = bi; cin = ci; en = ei; rst_n = ri; a8 = a8i; b8 = b8i;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; cin = 1'b0; a = '0; b = '0; a8 = '0; b8 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_sum_q4", {28'b0, sum_q4}, 32'd0);
        check("rst_flags_q4", {28'b0, valid_q4, zero_q4, ovf_q4, cout_q4}, 32'd0);
        check("rst_valid_q8", {31'b0, valid_q8}, 32'd0);
        check("model_ovf", {30'b0, ref_add(4, 32'd7, 32'd1, 1'b0)}, {30'b0, 2'b10, 32'd8});
        check("model_wrap", {30'b0, ref_add(4, 32'd15, 32'd15, 1'b1)}, {30'b0, 2'b01, 32'd15});
        check("model_neg", {30'b0, ref_add(4, 32'd8, 32'd8, 1'b0)}, {30'b0, 2'b11, 32'd0});
        chk_on = 1'b1;
        for (int i = 0; i < 512; i++) begin
            logic [8:0] v;
            v = 9'(i);
            step(v[8:5], v[4:1], v[0], 1'($urandom), 1'b1, 8'($urandom), 8'($urandom));
        end
        step(4'b1010, 4'b0111, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        check("lit_1010_0111", {27'b0, cout4, sum4}, 32'h12);
        step(4'b1111, 4'b0000, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        check("lit_ripple", {27'b0, cout4, sum4}, 32'h10);
        step(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
        check("lit_wrap", {27'b0, cout4, sum4}, 32'h1F);
        step(4'b0111, 4'b0001, 1'b0, 1'b1, 1'b1, 8'hFF, 8'h01);
        check("lit_w8_comb", {23'b0, cout8, sum8}, 32'h100);
        step(4'b1000, 4'b1000, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        check("lit_ovf_q4", {24'b0, valid_q4, zero_q4, ovf_q4, cout_q4, sum_q4}, 32'hA8);
        check("lit_w8_q", {29'b0, zero_q8, ovf_q8, cout_q8}, 32'h5);
        step(4'b0011, 4'b0100, 1'b0, 1'b1, 1'b1, 8'h00, 8'h00);
        check("lit_neg_ovf_q4", {24'b0, valid_q4, zero_q4, ovf_q4, cout_q4, sum_q4}, 32'hF0);
        step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        check("lit_capture", {27'b0, valid_q4, sum_q4}, 32'h17);
        check("lit_comb_now", {28'b0, sum4}, 32'h2);
        step(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        check("lit_hold", {27'b0, valid_q4, sum_q4}, 32'h17);
        step(4'b0101, 4'b0110, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
        check("lit_pre_rst", {27'b0, valid_q4, sum_q4}, 32'h17);
        check("lit_rst_comb", {28'b0, sum4}, 32'hB);
        step(4'b0010, 4'b0011, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        check("lit_post_rst", {24'b0, valid_q4, zero_q4, ovf_q4, cout_q4, sum_q4}, 32'h0);
        check("lit_post_rst8", {23'b0, valid_q8, sum_q8}, 32'h0);
        check("lit_post_comb", {28'b0, sum4}, 32'h5);
        for (int i = 0; i < 300; i++)
            step(4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 15) != 0), 8'($urandom), 8'($urandom));
        chk_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
